// File: rtl/draw_pkg.sv
// Shared definitions for the draw command path: opcodes, command field layout,
// screen limits in superpixels, the decoded-command struct and the dispatcher states.
// No logic lives here apart from the y clamp helper used by the decoder.
package draw_pkg;

   // Width of one command word as it leaves the command FIFO
   localparam int CMD_W   = 32;
   localparam int COORD_W = 5;
   localparam int COLOR_W = 8;
   localparam int OP_W    = 4;

   // Default screen extent: last superpixel column and row
   localparam logic [COORD_W-1:0] X_MAX_DEF = 5'd31;
   localparam logic [COORD_W-1:0] Y_MAX_DEF = 5'd23;

   // Opcodes; every other value is illegal
   localparam logic [OP_W-1:0] OP_PIXEL = 4'd0;
   localparam logic [OP_W-1:0] OP_RECT  = 4'd1;
   localparam logic [OP_W-1:0] OP_CLEAR = 4'd2;

   // Field offsets (LSB position) inside the command word
   localparam int OP_LSB   = 28;
   localparam int X0_LSB   = 23;
   localparam int Y0_LSB   = 18;
   localparam int X1_LSB   = 13;
   localparam int Y1_LSB   = 8;
   localparam int RCOL_LSB = 0;   // rectangle / clear color
   localparam int PCOL_LSB = 10;  // pixel color

   // Command after decode, ready to drive an engine
   typedef struct packed {
      logic                 is_rect;  // rectangle engine (rect and clear ops)
      logic [COORD_W-1:0]   x0;
      logic [COORD_W-1:0]   y0;
      logic [COORD_W-1:0]   x1;
      logic [COORD_W-1:0]   y1;
      logic [COLOR_W-1:0]   color;
   } draw_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DISPATCH,
      ST_WAIT
   } disp_state_t;

   function automatic logic [COORD_W-1:0] clamp_y(input logic [COORD_W-1:0] y,
                                                  input logic [COORD_W-1:0] y_max);
      return (y > y_max) ? y_max : y;
   endfunction

endpackage

// File: rtl/draw_cmd_decode.sv
// Command decoder: field extract, opcode legality, rectangle corner swap, y clamp, clear expansion.
// Latency: purely combinational. Backpressure: none, the caller decides when to sample.
// Ports: cmd (raw 32-bit word) in; legal (opcode 0..2) and dec (engine-ready command) out.
module draw_cmd_decode
   import draw_pkg::*;
#(
   parameter logic [COORD_W-1:0] X_MAX = X_MAX_DEF,
   parameter logic [COORD_W-1:0] Y_MAX = Y_MAX_DEF
) (
   input  logic [CMD_W-1:0] cmd,
   output logic             legal,
   output draw_cmd_t        dec
);

   logic [OP_W-1:0]    op;
   logic [COORD_W-1:0] x0, y0, x1, y1;

   always_comb begin
      op    = cmd[OP_LSB +: OP_W];
      x0    = cmd[X0_LSB +: COORD_W];
      x1    = cmd[X1_LSB +: COORD_W];
      // Clamping before the swap gives the same corners as after, since clamp is monotonic
      y0    = clamp_y(cmd[Y0_LSB +: COORD_W], Y_MAX);
      y1    = clamp_y(cmd[Y1_LSB +: COORD_W], Y_MAX);
      legal = 1'b0;
      dec   = '0;
      case (op)
         OP_PIXEL: begin
            legal     = 1'b1;
            dec.x0    = x0;
            dec.y0    = y0;
            dec.x1    = x0;
            dec.y1    = y0;
            dec.color = cmd[PCOL_LSB +: COLOR_W];
         end
         OP_RECT: begin
            legal       = 1'b1;
            dec.is_rect = 1'b1;
            dec.x0      = (x0 <= x1) ? x0 : x1;
            dec.x1      = (x0 <= x1) ? x1 : x0;
            dec.y0      = (y0 <= y1) ? y0 : y1;
            dec.y1      = (y0 <= y1) ? y1 : y0;
            dec.color   = cmd[RCOL_LSB +: COLOR_W];
         end
         OP_CLEAR: begin
            // Clear is a full-screen rectangle on the rectangle engine
            legal       = 1'b1;
            dec.is_rect = 1'b1;
            dec.x1      = X_MAX;
            dec.y1      = Y_MAX;
            dec.color   = cmd[RCOL_LSB +: COLOR_W];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/draw_cmd_dispatch.sv
// Draw command dispatcher: pops one command, hands it to the pixel or rectangle engine, muxes RAM writes.
// Latency: rden -> rvld -> engine vld (2 cycles); engine done -> idle next cycle; 3 cycles overhead per command.
// Backpressure: one command in flight; FIFO is read only from IDLE, WAIT ends on done or timeout.
// Ports: ff_* command FIFO read side; pix_*/rect_* engine launch, done and RAM write inputs;
//        ram_* muxed VGA RAM write port; busy, err_cnt (illegal ops), tmo_cnt (engine timeouts).
module draw_cmd_dispatch
   import draw_pkg::*;
#(
   parameter logic [COORD_W-1:0] X_MAX       = X_MAX_DEF,
   parameter logic [COORD_W-1:0] Y_MAX       = Y_MAX_DEF,
   parameter logic [19:0]        TIMEOUT_MAX = 20'hFFFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   // command FIFO
   input  logic                 ff_empty,
   output logic                 ff_rden,
   input  logic [CMD_W-1:0]     ff_rdat,
   input  logic                 ff_rvld,
   // pixel engine
   output logic [COORD_W-1:0]   pix_x,
   output logic [COORD_W-1:0]   pix_y,
   output logic [COLOR_W-1:0]   pix_color,
   output logic                 pix_vld,
   input  logic                 pix_done,
   // rectangle engine
   output logic [COORD_W-1:0]   rect_x0,
   output logic [COORD_W-1:0]   rect_x1,
   output logic [COORD_W-1:0]   rect_y0,
   output logic [COORD_W-1:0]   rect_y1,
   output logic [COLOR_W-1:0]   rect_color,
   output logic                 rect_vld,
   input  logic                 rect_done,
   // engine RAM write ports
   input  logic [18:0]          pix_addr,
   input  logic [7:0]           pix_data,
   input  logic                 pix_wren,
   input  logic [18:0]          rect_addr,
   input  logic [7:0]           rect_data,
   input  logic                 rect_wren,
   // muxed VGA RAM write port
   output logic [18:0]          ram_addr,
   output logic [7:0]           ram_data,
   output logic                 ram_wren,
   // status
   output logic                 busy,
   output logic [7:0]           err_cnt,
   output logic [7:0]           tmo_cnt
);

   disp_state_t state, state_nxt;
   draw_cmd_t   dec, cur;
   logic        dec_legal;
   logic [19:0] wait_cnt;
   logic        done_act;
   logic        tmo_hit;

   draw_cmd_decode #(
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX)
   ) u_decode (
      .cmd   (ff_rdat),
      .legal (dec_legal),
      .dec   (dec)
   );

   // Only the engine that owns the current command can end WAIT
   assign done_act = cur.is_rect ? rect_done : pix_done;
   // wait_cnt is 0 on the first WAIT cycle, so this fires on the TIMEOUT_MAX-th one
   assign tmo_hit  = (wait_cnt == TIMEOUT_MAX - 20'd1);

   always_comb begin
      state_nxt = state;
      ff_rden   = 1'b0;
      pix_vld   = 1'b0;
      rect_vld  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!ff_empty) begin
               ff_rden   = 1'b1;
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (ff_rvld) state_nxt = dec_legal ? ST_DISPATCH : ST_IDLE;
         end
         ST_DISPATCH: begin
            pix_vld   = !cur.is_rect;
            rect_vld  = cur.is_rect;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (done_act || tmo_hit) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cur      <= '0;
         wait_cnt <= '0;
         err_cnt  <= '0;
         tmo_cnt  <= '0;
      end else begin
         state <= state_nxt;
         // Illegal words never reach cur, so engine outputs keep the last dispatched command
         if (state == ST_FETCH && ff_rvld) begin
            if (dec_legal)                cur     <= dec;
            else if (err_cnt != 8'hFF)    err_cnt <= err_cnt + 8'd1;
         end
         if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 20'd1;
            // A done arriving on the timeout cycle counts as a normal completion
            if (tmo_hit && !done_act && tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   assign pix_x      = cur.x0;
   assign pix_y      = cur.y0;
   assign pix_color  = cur.color;
   assign rect_x0    = cur.x0;
   assign rect_x1    = cur.x1;
   assign rect_y0    = cur.y0;
   assign rect_y1    = cur.y1;
   assign rect_color = cur.color;
   assign busy       = (state != ST_IDLE);

   always_comb begin
      ram_addr = '0;
      ram_data = '0;
      ram_wren = 1'b0;
      if (state == ST_DISPATCH || state == ST_WAIT) begin
         if (cur.is_rect) begin
            ram_addr = rect_addr;
            ram_data = rect_data;
            ram_wren = rect_wren;
         end else begin
            ram_addr = pix_addr;
            ram_data = pix_data;
            ram_wren = pix_wren;
         end
      end
   end

endmodule

// File: tb/tb_draw_cmd_dispatch.sv
// Bench for draw_cmd_dispatch: FIFO and engine responders driven from a transaction timeline model.
// Each command is placed on a cycle timeline (read, fetch, launch, end) from plain arithmetic.
// Every cycle all DUT outputs are compared against that timeline; literal checks pin the model.
module tb_draw_cmd_dispatch;

   localparam int T  = 16;
   localparam int XM = 31;
   localparam int YM = 23;

   logic        clk = 1'b0;
   logic        rst;
   logic        ff_empty, ff_rden, ff_rvld;
   logic [31:0] ff_rdat;
   logic [4:0]  pix_x, pix_y, rect_x0, rect_x1, rect_y0, rect_y1;
   logic [7:0]  pix_color, rect_color, pix_data, rect_data, ram_data, err_cnt, tmo_cnt;
   logic        pix_vld, pix_done, rect_vld, rect_done, pix_wren, rect_wren, ram_wren, busy;
   logic [18:0] pix_addr, rect_addr, ram_addr;

   always #10 clk = ~clk;

   draw_cmd_dispatch #(.X_MAX(5'd31), .Y_MAX(5'd23), .TIMEOUT_MAX(20'd16)) dut (
      .clk(clk), .rst(rst),
      .ff_empty(ff_empty), .ff_rden(ff_rden), .ff_rdat(ff_rdat), .ff_rvld(ff_rvld),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_vld(pix_vld), .pix_done(pix_done),
      .rect_x0(rect_x0), .rect_x1(rect_x1), .rect_y0(rect_y0), .rect_y1(rect_y1),
      .rect_color(rect_color), .rect_vld(rect_vld), .rect_done(rect_done),
      .pix_addr(pix_addr), .pix_data(pix_data), .pix_wren(pix_wren),
      .rect_addr(rect_addr), .rect_data(rect_data), .rect_wren(rect_wren),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
      .busy(busy), .err_cnt(err_cnt), .tmo_cnt(tmo_cnt)
   );

   typedef struct {
      bit legal;
      bit is_rect;
      int x0, y0, x1, y1, color;
   } exp_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          rst_cyc = -1;
   logic [31:0] fifo_q[$];
   int          d_q[$];
   bit          txn = 0;
   bit          pend_rvld = 0;
   logic [31:0] pend_dat;
   int          t_rden, t_end, dly;
   exp_t        ex;
   int          m_err = 0, m_tmo = 0, vld_seen = 0;
   int          cap_px, cap_py, cap_pc, cap_rx0, cap_ry0, cap_rx1, cap_ry1, cap_rc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // What a command word must turn into, straight from the command rules
   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      int op, a, b, c, d;
      op = int'(w[31:28]);
      a  = int'(w[27:23]);
      b  = int'(w[22:18]);
      c  = int'(w[17:13]);
      d  = int'(w[12:8]);
      if (b > YM) b = YM;
      if (d > YM) d = YM;
      e = '{legal: (op < 3), is_rect: (op != 0), x0: 0, y0: 0, x1: 0, y1: 0, color: 0};
      if (op == 0) begin
         e.x0 = a; e.y0 = b; e.color = int'(w[17:10]);
      end else if (op == 1) begin
         e.x0 = (a < c) ? a : c;  e.x1 = (a < c) ? c : a;
         e.y0 = (b < d) ? b : d;  e.y1 = (b < d) ? d : b;
         e.color = int'(w[7:0]);
      end else if (op == 2) begin
         e.x1 = XM; e.y1 = YM; e.color = int'(w[7:0]);
      end
      return e;
   endfunction

   function automatic logic [31:0] mk_pix(input int x, input int y, input int col);
      return {4'd0, 5'(x), 5'(y), 8'(col), 10'd0};
   endfunction

   function automatic logic [31:0] mk_rect(input int x0, input int y0, input int x1, input int y1,
                                           input int col);
      return {4'd1, 5'(x0), 5'(y0), 5'(x1), 5'(y1), 8'(col)};
   endfunction

   function automatic logic [31:0] mk_op(input int op, input logic [27:0] low);
      return {4'(op), low};
   endfunction

   // One clock cycle: drive inputs at negedge, sample #1 later, then advance the timeline
   task automatic step();
      bit          in_rst, in_wait, act_done, disp_on, exp_pv, exp_rv;
      logic [27:0] exp_ram;
      @(negedge clk);
      cyc++;
      in_rst = (cyc == rst_cyc);
      if (txn && cyc > t_end) txn = 0;
      rst       = in_rst;
      ff_empty  = (fifo_q.size() == 0);
      ff_rvld   = pend_rvld;
      ff_rdat   = pend_rvld ? pend_dat : 32'($urandom);
      pend_rvld = 0;
      pix_wren  = 1'($urandom);   pix_addr  = 19'($urandom); pix_data  = 8'($urandom);
      rect_wren = 1'($urandom);   rect_addr = 19'($urandom); rect_data = 8'($urandom);
      // Launch on t_rden+2, WAIT from t_rden+3 through t_end
      in_wait  = txn && ex.legal && cyc >= t_rden + 3 && cyc <= t_end;
      act_done = in_wait && dly <= T && cyc == t_rden + 2 + dly;
      pix_done  = ($urandom_range(0, 3) == 0);
      rect_done = ($urandom_range(0, 3) == 0);
      if (in_wait) begin
         if (ex.is_rect) rect_done = act_done;
         else            pix_done  = act_done;
      end
      #1;
      if (!in_rst) begin
         disp_on = txn && ex.legal && cyc >= t_rden + 2;
         exp_pv  = disp_on && !ex.is_rect && cyc == t_rden + 2;
         exp_rv  = disp_on &&  ex.is_rect && cyc == t_rden + 2;
         chk("busy", busy, txn && cyc > t_rden);
         chk("ff_rden", ff_rden, !txn && fifo_q.size() > 0);
         chk("pix_vld", pix_vld, exp_pv);
         chk("rect_vld", rect_vld, exp_rv);
         if (disp_on && !ex.is_rect)
            chk("pix_fields", {pix_x, pix_y, pix_color}, {5'(ex.x0), 5'(ex.y0), 8'(ex.color)});
         if (disp_on && ex.is_rect)
            chk("rect_fields", {rect_x0, rect_y0, rect_x1, rect_y1, rect_color},
                {5'(ex.x0), 5'(ex.y0), 5'(ex.x1), 5'(ex.y1), 8'(ex.color)});
         exp_ram = !disp_on ? 28'd0 :
                   ex.is_rect ? {rect_wren, rect_addr, rect_data} : {pix_wren, pix_addr, pix_data};
         chk("ram_port", {ram_wren, ram_addr, ram_data}, exp_ram);
         chk("err_cnt", err_cnt, m_err);
         chk("tmo_cnt", tmo_cnt, m_tmo);
      end
      if (pix_vld === 1'b1) begin
         vld_seen++; cap_px = pix_x; cap_py = pix_y; cap_pc = pix_color;
      end
      if (rect_vld === 1'b1) begin
         vld_seen++; cap_rx0 = rect_x0; cap_ry0 = rect_y0;
         cap_rx1 = rect_x1; cap_ry1 = rect_y1; cap_rc = rect_color;
      end
      if (in_rst) begin
         txn = 0; m_err = 0; m_tmo = 0;
      end else begin
         if (txn && !ex.legal && cyc == t_rden + 1 && m_err < 255) m_err++;
         if (txn && ex.legal && dly > T && cyc == t_end && m_tmo < 255) m_tmo++;
         if (!txn && fifo_q.size() > 0) begin
            pend_dat  = fifo_q.pop_front();
            pend_rvld = 1;
            txn       = 1;
            t_rden    = cyc;
            ex        = model(pend_dat);
            dly       = (d_q.size() > 0) ? d_q.pop_front() : int'($urandom_range(1, 20));
            if (!ex.legal)    t_end = cyc + 1;
            else if (dly <= T) t_end = cyc + 2 + dly;
            else               t_end = cyc + 2 + T;
         end
      end
   endtask

   task automatic run_idle(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while ((txn || fifo_q.size() > 0) && n < 20000);
      chk({"idle_reached_", tag}, (txn || fifo_q.size() > 0), 0);
   endtask

   initial begin
      rst = 1'b1; ff_empty = 1'b1; ff_rvld = 1'b0; ff_rdat = '0;
      pix_done = 1'b0; rect_done = 1'b0;
      pix_wren = 1'b0; pix_addr = '0; pix_data = '0;
      rect_wren = 1'b0; rect_addr = '0; rect_data = '0;
      repeat (3) @(negedge clk);

      // Reset state
      step();
      chk("rst_busy", busy, 0);
      chk("rst_rden", ff_rden, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_tmo", tmo_cnt, 0);
      chk("rst_ram_wren", ram_wren, 0);
      chk("rst_regs", {pix_x, pix_y, rect_x1, rect_y1, rect_color}, 0);

      // Pixel (3,4) color 0x0F
      fifo_q.push_back(mk_pix(3, 4, 8'h0F)); d_q.push_back(3);
      run_idle("pix");
      chk("lit_pix", {5'(cap_px), 5'(cap_py), 8'(cap_pc)}, {5'd3, 5'd4, 8'h0F});

      // Rectangle with swapped corners
      fifo_q.push_back(mk_rect(20, 14, 10, 10, 8'hAA)); d_q.push_back(2);
      run_idle("rect");
      chk("lit_rect", {5'(cap_rx0), 5'(cap_ry0), 5'(cap_rx1), 5'(cap_ry1), 8'(cap_rc)},
          {5'd10, 5'd10, 5'd20, 5'd14, 8'hAA});

      // Clear screen with color 0
      fifo_q.push_back(mk_op(2, 28'hFFFFF00)); d_q.push_back(5);
      run_idle("clear");
      chk("lit_clear", {5'(cap_rx0), 5'(cap_ry0), 5'(cap_rx1), 5'(cap_ry1), 8'(cap_rc)},
          {5'd0, 5'd0, 5'd31, 5'd23, 8'h00});
      chk("lit_vld_count3", vld_seen, 3);

      // Illegal opcode 7
      fifo_q.push_back(mk_op(7, 28'($urandom)));
      run_idle("op7");
      chk("lit_err1", err_cnt, 1);
      chk("lit_vld_count_op7", vld_seen, 3);

      // Done withheld: timeout after T WAIT cycles
      fifo_q.push_back(mk_pix(7, 9, 8'h33)); d_q.push_back(99);
      run_idle("timeout");
      chk("lit_tmo1", tmo_cnt, 1);

      // Reset in the middle of WAIT (y=30 clamps to 23)
      fifo_q.push_back(mk_pix(5, 30, 8'h44)); d_q.push_back(99);
      rst_cyc = cyc + 6;
      repeat (7) step();
      chk("lit_rstwait_busy", busy, 0);
      chk("lit_rstwait_cnts", {err_cnt, tmo_cnt}, 16'd0);
      chk("lit_rstwait_ram", ram_wren, 0);
      chk("lit_rstwait_regs", {pix_x, pix_y, pix_color}, 18'd0);

      // Done on the same cycle the timeout would fire
      fifo_q.push_back(mk_rect(1, 2, 3, 4, 8'h55)); d_q.push_back(T);
      run_idle("done_tmo");
      chk("lit_tmo_done_same", tmo_cnt, 0);

      // 256 illegal opcodes saturate the error counter
      for (int i = 0; i < 256; i++) fifo_q.push_back(mk_op($urandom_range(3, 15), 28'($urandom)));
      run_idle("illegal256");
      chk("lit_err_sat", err_cnt, 255);

      // Random mix, mostly legal, with idle gaps between bursts
      for (int b = 0; b < 10; b++) begin
         for (int i = 0; i < 30; i++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 15)) : int'($urandom_range(0, 2));
            fifo_q.push_back(mk_op(op, 28'($urandom)));
         end
         run_idle("random");
         repeat ($urandom_range(0, 5)) step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
